// File: rtl/fp_normalize_round.sv
// fp_normalize_round
//
// Normalizes and rounds NUM_LANES float32 results in a two-stage pipeline
// with valid/ready handshakes on both sides. It also keeps a set of sticky
// exception flags for each thread.
//
// Stage A: left-shifts each significand by its normalization amount and
//          adjusts the exponent to match.
// Stage B: rounds, handles the special cases and packs the float32 result.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-low reset
//   in_valid, in_ready  input handshake; a beat transfers when both are high
//   in_thread           thread that owns the beat
//   in_mask             per-lane enable (gates the flag contribution)
//   in_round_mode       0=RNE 1=RTZ 2=RUP 3=RDN
//   in_sign             per-lane result sign
//   in_exponent         per-lane signed biased exponent, 10 bits per lane
//   in_significand      per-lane unnormalized significand, 32 bits per lane
//   in_norm_shift       per-lane left shift amount, 6 bits per lane
//   in_inf, in_nan      per-lane special-result flags
//   out_valid/out_ready output handshake
//   out_thread/out_mask carried through with the beat
//   out_result          per-lane float32 result, 32 bits per lane
//   flag_clear          clears the sticky flags of flag_clear_thread
//   fp_flags            per-thread {invalid, overflow, underflow, inexact}
//
// Configuration macro
//   FP_ROUND_MODES_EN   defined: all four rounding modes are honoured.
//                       undefined: in_round_mode is ignored, RNE is always
//                       used, so overflow always produces infinity.
module fp_normalize_round #(
  parameter int NUM_LANES   = 16,
  parameter int NUM_THREADS = 4,
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TW-1:0]           in_thread,
  input  logic [NUM_LANES-1:0]    in_mask,
  input  logic [1:0]              in_round_mode,
  input  logic [NUM_LANES-1:0]    in_sign,
  input  logic [NUM_LANES*10-1:0] in_exponent,
  input  logic [NUM_LANES*32-1:0] in_significand,
  input  logic [NUM_LANES*6-1:0]  in_norm_shift,
  input  logic [NUM_LANES-1:0]    in_inf,
  input  logic [NUM_LANES-1:0]    in_nan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TW-1:0]           out_thread,
  output logic [NUM_LANES-1:0]    out_mask,
  output logic [NUM_LANES*32-1:0] out_result,
  input  logic                    flag_clear,
  input  logic [TW-1:0]           flag_clear_thread,
  output logic [NUM_THREADS*4-1:0] fp_flags
);

  // Pipeline control state
  logic aValid_q;
  logic bValid_q;
  logic aAccept;
  logic bAccept;
  logic aLoad;
  logic bLoad;

  // Stage A registers (datapath, not reset)
  logic [NUM_LANES*32-1:0] aSig_q;
  logic [NUM_LANES*11-1:0] aExp_q;
  logic [NUM_LANES-1:0]    aSign_q;
  logic [NUM_LANES-1:0]    aInf_q;
  logic [NUM_LANES-1:0]    aNan_q;
  logic [1:0]              aMode_q;
  logic [TW-1:0]           aThread_q;
  logic [NUM_LANES-1:0]    aMask_q;

  // Stage A next-state values
  logic [NUM_LANES*32-1:0] aSig_d;
  logic [NUM_LANES*11-1:0] aExp_d;

  // Stage B registers (datapath, not reset)
  logic [NUM_LANES*32-1:0] bResult_q;
  logic [3:0]              bFlags_q;
  logic [TW-1:0]           bThread_q;
  logic [NUM_LANES-1:0]    bMask_q;

  // Stage B next-state values
  logic [NUM_LANES*32-1:0] bResult_d;
  logic [NUM_LANES*4-1:0]  laneFlags;
  logic [3:0]              bFlags_d;

  // Sticky flags
  logic [NUM_THREADS*4-1:0] flags_q;
  logic [NUM_THREADS*4-1:0] flags_d;

  // Effective rounding mode used by stage B
  logic [1:0] effMode;

`ifdef FP_ROUND_MODES_EN
  assign effMode = aMode_q;
`else
  // The captured mode is deliberately ignored; RNE is hard-wired.
  logic unusedMode;
  assign unusedMode = ^aMode_q;
  assign effMode    = 2'd0;
`endif

  // Handshake. Each stage takes a new beat when it is empty or when its own
  // contents are moving on in the same cycle. The input side can therefore
  // accept whenever a bubble exists anywhere or the consumer is draining.
  always_comb begin
    bAccept  = !bValid_q || out_ready;
    aAccept  = !aValid_q || bAccept;
    aLoad    = in_valid && aAccept;
    bLoad    = aValid_q && bAccept;
    in_ready = aAccept;
  end

  // Valid bits are the only pipeline state that needs reset. Clearing them
  // discards any beats that are in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aValid_q <= 1'b0;
      bValid_q <= 1'b0;
    end else begin
      if (aAccept) begin
        aValid_q <= in_valid;
      end
      if (bAccept) begin
        bValid_q <= aValid_q;
      end
    end
  end

  // Stage A per-lane shift and exponent adjustment. A shift of 32 or more
  // clears the significand. The 10-bit signed exponent is sign-extended to
  // 11 bits before the unsigned shift amount is subtracted.
  for (genvar i = 0; i < NUM_LANES; i++) begin : gLaneA
    logic [9:0] expIn;
    logic [5:0] shiftIn;
    assign expIn   = in_exponent[i*10 +: 10];
    assign shiftIn = in_norm_shift[i*6 +: 6];
    assign aSig_d[i*32 +: 32] = in_significand[i*32 +: 32] << shiftIn;
    assign aExp_d[i*11 +: 11] = {expIn[9], expIn} - {5'd0, shiftIn};
  end

  // Stage A capture. While stage A is holding a stalled beat, aLoad is low,
  // so the register keeps its contents.
  always_ff @(posedge clk) begin
    if (aLoad) begin
      aSig_q    <= aSig_d;
      aExp_q    <= aExp_d;
      aSign_q   <= in_sign;
      aInf_q    <= in_inf;
      aNan_q    <= in_nan;
      aMode_q   <= in_round_mode;
      aThread_q <= in_thread;
      aMask_q   <= in_mask;
    end
  end

  // Stage B per-lane rounding and packing.
  // Fields of the shifted significand: s[31] is the hidden bit, s[30:8] is
  // the mantissa, s[7] is the guard bit and s[6:0] form the sticky bit.
  // The special cases are checked in priority order: NaN, infinity, zero,
  // flush, overflow. Flush is decided on the exponent before rounding, so a
  // round-up carry cannot rescue a flushed value. Overflow is decided on
  // the exponent after rounding.
  for (genvar i = 0; i < NUM_LANES; i++) begin : gLaneB
    logic [31:0]        s;
    logic signed [10:0] e;
    logic signed [10:0] eRnd;
    logic               sign;
    logic               guard;
    logic               sticky;
    logic               lsb;
    logic               roundUp;
    logic               carry;
    logic               toInf;
    logic [22:0]        mantRnd;
    logic [31:0]        result;
    logic [3:0]         flags;

    assign s    = aSig_q[i*32 +: 32];
    assign e    = $signed(aExp_q[i*11 +: 11]);
    assign sign = aSign_q[i];

    always_comb begin
      guard  = s[7];
      sticky = |s[6:0];
      lsb    = s[8];

      roundUp = 1'b0;
      case (effMode)
        2'd0:    roundUp = guard && (sticky || lsb);
        2'd1:    roundUp = 1'b0;
        2'd2:    roundUp = (guard || sticky) && !sign;
        default: roundUp = (guard || sticky) && sign;
      endcase

      {carry, mantRnd} = {1'b0, s[30:8]} + {23'd0, roundUp};
      eRnd = e + $signed({10'd0, carry});

      // Saturate to infinity only when rounding is allowed to move the
      // magnitude up; otherwise clamp to the largest finite value.
      toInf = (effMode == 2'd0) ||
              ((effMode == 2'd2) && !sign) ||
              ((effMode == 2'd3) && sign);

      result = {sign, eRnd[7:0], mantRnd};
      flags  = {3'b000, guard || sticky};

      if (aNan_q[i]) begin
        result = 32'h7FFF_FFFF;
        flags  = 4'b1000;
      end else if (aInf_q[i]) begin
        result = {sign, 8'hFF, 23'd0};
        flags  = 4'b0000;
      end else if (s == 32'd0) begin
        result = {sign, 31'd0};
        flags  = 4'b0000;
      end else if (e <= 11'sd0) begin
        result = {sign, 31'd0};
        flags  = 4'b0011;
      end else if (eRnd >= 11'sd255) begin
        result = toInf ? {sign, 8'hFF, 23'd0} : {sign, 31'h7F7F_FFFF};
        flags  = 4'b0101;
      end
    end

    assign bResult_d[i*32 +: 32] = result;
    assign laneFlags[i*4 +: 4]   = flags & {4{aMask_q[i]}};
  end

  // Merge the flags of the enabled lanes into one 4-bit set for the beat.
  always_comb begin
    bFlags_d = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      bFlags_d = bFlags_d | laneFlags[i*4 +: 4];
    end
  end

  // Stage B capture. This stage holds its beat while the consumer stalls.
  always_ff @(posedge clk) begin
    if (bLoad) begin
      bResult_q <= bResult_d;
      bFlags_q  <= bFlags_d;
      bThread_q <= aThread_q;
      bMask_q   <= aMask_q;
    end
  end

  assign out_valid  = bValid_q;
  assign out_thread = bThread_q;
  assign out_mask   = bMask_q;
  assign out_result = bResult_q;

  // Sticky flag next state. A clear is applied before the flags of a
  // departing beat are ORed in, so a clear and an update on the same
  // thread in the same cycle leave only the new flags.
  always_comb begin
    flags_d = flags_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (flag_clear && (flag_clear_thread == TW'(t))) begin
        flags_d[t*4 +: 4] = 4'd0;
      end
      if (bValid_q && out_ready && (bThread_q == TW'(t))) begin
        flags_d[t*4 +: 4] = flags_d[t*4 +: 4] | bFlags_q;
      end
    end
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign fp_flags = flags_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round
//
// Self-checking bench for fp_normalize_round. A scoreboard queue holds the
// expected beats. They are computed when each beat is accepted, using an
// arithmetic reference model of the rounding rules. The bench also keeps a
// model of the per-thread sticky flags. Directed cases cover ties, mantissa
// carry, overflow, flush, masked NaN, clear/update collision, backpressure
// and reset in mid-stream.
`timescale 1ns/1ps
module tb_fp_normalize_round;

  localparam int NL = 16;
  localparam int NT = 4;
  localparam int TW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [TW-1:0]     in_thread = '0;
  logic [NL-1:0]     in_mask = '0;
  logic [1:0]        in_round_mode = '0;
  logic [NL-1:0]     in_sign = '0;
  logic [NL*10-1:0]  in_exponent = '0;
  logic [NL*32-1:0]  in_significand = '0;
  logic [NL*6-1:0]   in_norm_shift = '0;
  logic [NL-1:0]     in_inf = '0;
  logic [NL-1:0]     in_nan = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [TW-1:0]     out_thread;
  logic [NL-1:0]     out_mask;
  logic [NL*32-1:0]  out_result;
  logic              flag_clear = 1'b0;
  logic [TW-1:0]     flag_clear_thread = '0;
  logic [NT*4-1:0]   fp_flags;

  typedef struct {
    logic [NL*32-1:0] res;
    logic [3:0]       flags;
    logic [TW-1:0]    thread;
    logic [NL-1:0]    mask;
  } beat_t;

  beat_t           sb[$];
  logic [NT*4-1:0] modelFlags = '0;
  int              checks = 0;
  int              errors = 0;
  int              outCount = 0;

  fp_normalize_round #(.NUM_LANES(NL), .NUM_THREADS(NT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_thread(in_thread), .in_mask(in_mask), .in_round_mode(in_round_mode),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_significand(in_significand),
    .in_norm_shift(in_norm_shift), .in_inf(in_inf), .in_nan(in_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_thread(out_thread), .out_mask(out_mask), .out_result(out_result),
    .flag_clear(flag_clear), .flag_clear_thread(flag_clear_thread),
    .fp_flags(fp_flags)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference for one lane: returns {flags[3:0], result[31:0]}, built from
  // integer arithmetic on the shifted value, mantissa and remainder
  function automatic logic [35:0] modelLane(input logic [31:0] sig, input logic [9:0] expIn,
                                            input logic [5:0] shift, input logic sign,
                                            input int mode, input logic inf, input logic nan);
    longint s;
    int     e, m, rem;
    bit     up, toInf;
    if (nan) return {4'b1000, 32'h7FFF_FFFF};
    if (inf) return {4'b0000, sign, 8'hFF, 23'd0};
    s = (longint'(sig) << shift) & 64'hFFFF_FFFF;
    e = int'($signed(expIn)) - int'(shift);
    if (s == 0) return {4'b0000, sign, 31'd0};
    if (e <= 0) return {4'b0011, sign, 31'd0};
    m   = int'((s >> 8) & 64'h7F_FFFF);
    rem = int'(s & 64'hFF);
    case (mode)
      0:       up = (rem > 128) || (rem == 128 && (m % 2) == 1);
      1:       up = 1'b0;
      2:       up = (rem != 0) && !sign;
      default: up = (rem != 0) && sign;
    endcase
    m = m + int'(up);
    if (m == (1 << 23)) begin
      m = 0;
      e = e + 1;
    end
    if (e >= 255) begin
      toInf = (mode == 0) || (mode == 2 && !sign) || (mode == 3 && sign);
      if (toInf) return {4'b0101, sign, 8'hFF, 23'd0};
      return {4'b0101, sign, 31'h7F7F_FFFF};
    end
    return {3'b000, (rem != 0), sign, 8'(e), 23'(m)};
  endfunction

  // Expected beat for whatever is currently driven on the input port
  function automatic beat_t modelBeat();
    beat_t       b;
    logic [35:0] r;
    int          mode;
`ifdef FP_ROUND_MODES_EN
    mode = int'(in_round_mode);
`else
    mode = 0;
`endif
    b.flags  = 4'd0;
    b.thread = in_thread;
    b.mask   = in_mask;
    b.res    = '0;
    for (int i = 0; i < NL; i++) begin
      r = modelLane(in_significand[i*32 +: 32], in_exponent[i*10 +: 10],
                    in_norm_shift[i*6 +: 6], in_sign[i], mode, in_inf[i], in_nan[i]);
      b.res[i*32 +: 32] = r[31:0];
      if (in_mask[i]) b.flags = b.flags | r[35:32];
    end
    return b;
  endfunction

  // Monitor: compares each departing beat with the scoreboard, and keeps
  // the flag model and the occupancy-based ready expectation up to date
  always @(negedge clk) begin
    beat_t           expBeat;
    logic [NT*4-1:0] nextFlags;
    if (!reset) begin
      sb.delete();
      modelFlags = '0;
    end else begin
      checkOutput("flags", 64'(fp_flags), 64'(modelFlags));
      checkOutput("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
      nextFlags = modelFlags;
      if (flag_clear) nextFlags[flag_clear_thread*4 +: 4] = 4'd0;
      if (out_valid && out_ready) begin
        outCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", 64'(out_valid), 64'(0));
        end else begin
          expBeat = sb.pop_front();
          for (int i = 0; i < NL; i++) begin
            checkOutput($sformatf("lane%0d", i), 64'(out_result[i*32 +: 32]), 64'(expBeat.res[i*32 +: 32]));
          end
          checkOutput("out_thread", 64'(out_thread), 64'(expBeat.thread));
          checkOutput("out_mask", 64'(out_mask), 64'(expBeat.mask));
          nextFlags[expBeat.thread*4 +: 4] = nextFlags[expBeat.thread*4 +: 4] | expBeat.flags;
        end
      end
      modelFlags = nextFlags;
      if (in_valid && in_ready) sb.push_back(modelBeat());
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic zeroBeat();
    in_thread      = '0;
    in_mask        = '0;
    in_round_mode  = '0;
    in_sign        = '0;
    in_exponent    = '0;
    in_significand = '0;
    in_norm_shift  = '0;
    in_inf         = '0;
    in_nan         = '0;
  endtask

  // Randomizes every beat field. The weighted lane kinds aim at ties,
  // large shifts, edge exponents, zeros and special values.
  task automatic applyStimulus();
    int kind, ev;
    logic [31:0] sig;
    in_thread     = TW'($urandom_range(0, NT-1));
    in_mask       = NL'($urandom);
    in_round_mode = 2'($urandom);
    for (int i = 0; i < NL; i++) begin
      kind = $urandom_range(0, 19);
      sig  = $urandom;
      if (kind < 3) sig = sig >> $urandom_range(0, 31);
      if (kind == 6) sig = 32'd0;
      if (kind == 9) sig = (sig & 32'hFFFF_FF00) | 32'h80;
      ev = $urandom_range(0, 300) - 20;
      if (kind == 4) ev = $urandom_range(252, 258);
      if (kind == 5) ev = $urandom_range(0, 3);
      in_significand[i*32 +: 32] = sig;
      in_exponent[i*10 +: 10]    = 10'(ev);
      in_norm_shift[i*6 +: 6]    = (kind == 3) ? 6'($urandom_range(0, 63)) :
                                   (kind == 9) ? 6'd0 : 6'($urandom_range(0, 9));
      in_sign[i] = 1'($urandom);
      in_inf[i]  = (kind == 7);
      in_nan[i]  = (kind == 8) || (kind == 7 && $urandom_range(0, 1) == 1);
    end
  endtask

  // Launches the prepared beat with a flag clear of its thread. Then waits
  // (bounded) for the result and checks the two-cycle latency.
  task automatic runBeat(input string tag, input logic [TW-1:0] thr);
    int lat;
    bit found;
    in_thread         = thr;
    in_valid          = 1'b1;
    out_ready         = 1'b1;
    flag_clear        = 1'b1;
    flag_clear_thread = thr;
    stepCycle();
    in_valid   = 1'b0;
    flag_clear = 1'b0;
    lat   = 0;
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) found = 1;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(2));
  endtask

  task automatic directedCase(input string tag, input logic [1:0] mode, input logic [31:0] sig,
                              input logic [9:0] expv, input logic sign,
                              input logic [31:0] expRes, input logic [3:0] expFlags);
    stepCycle();
    zeroBeat();
    in_round_mode          = mode;
    in_mask                = 16'h0001;
    in_significand[31:0]   = sig;
    in_exponent[9:0]       = expv;
    in_sign[0]             = sign;
    runBeat(tag, 2'd1);
    checkOutput({tag, "_result"}, 64'(out_result[31:0]), 64'(expRes));
    @(negedge clk);
    checkOutput({tag, "_flags"}, 64'(fp_flags[7:4]), 64'(expFlags));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted;
    int outBase;
    bit found;

    // Values while reset is held low
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset_fp_flags", 64'(fp_flags), 64'(0));
    reset = 1'b1;

    // Directed rounding cases
    directedCase("tie_even", 2'd0, 32'h8000_0180, 10'd127, 1'b0, 32'h3F80_0002, 4'b0001);
    directedCase("mant_carry", 2'd0, 32'hFFFF_FF80, 10'd127, 1'b0, 32'h4000_0000, 4'b0001);
    directedCase("overflow_rne", 2'd0, 32'hFFFF_FF80, 10'd254, 1'b0, 32'h7F80_0000, 4'b0101);
`ifdef FP_ROUND_MODES_EN
    directedCase("overflow_rtz", 2'd1, 32'hFFFF_FF80, 10'd254, 1'b0, 32'h7F7F_FFFF, 4'b0001);
    directedCase("rup_negative", 2'd2, 32'hFFFF_FF81, 10'd254, 1'b1, 32'hFF7F_FFFF, 4'b0001);
    directedCase("rdn_overflow", 2'd3, 32'hFFFF_FF81, 10'd255, 1'b0, 32'h7F7F_FFFF, 4'b0101);
`else
    directedCase("overflow_rtz", 2'd1, 32'hFFFF_FF80, 10'd254, 1'b0, 32'h7F80_0000, 4'b0101);
    directedCase("rup_negative", 2'd2, 32'hFFFF_FF81, 10'd254, 1'b1, 32'hFF80_0000, 4'b0101);
    directedCase("rdn_overflow", 2'd3, 32'hFFFF_FF81, 10'd255, 1'b0, 32'h7F80_0000, 4'b0101);
`endif
    directedCase("flush", 2'd0, 32'h8000_0000, 10'd0, 1'b1, 32'h8000_0000, 4'b0011);
    directedCase("signed_zero", 2'd0, 32'h0000_0000, 10'd100, 1'b1, 32'h8000_0000, 4'b0000);

    // NaN in a masked-off lane contributes no invalid flag
    stepCycle();
    zeroBeat();
    in_mask              = 16'h0001;
    in_significand[31:0] = 32'hFFFF_FF80;
    in_exponent[9:0]     = 10'd254;
    in_nan[5]            = 1'b1;
    runBeat("nan_masked", 2'd2);
    checkOutput("nan_lane_result", 64'(out_result[5*32 +: 32]), 64'(32'h7FFF_FFFF));
    @(negedge clk);
    checkOutput("nan_masked_flags", 64'(fp_flags[11:8]), 64'(4'b0101));

    // NaN in an enabled lane, transferred in the same cycle as a clear
    stepCycle();
    zeroBeat();
    in_thread  = 2'd2;
    in_mask    = 16'h0020;
    in_nan[5]  = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    stepCycle();
    in_valid = 1'b0;
    found    = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    checkOutput("nan_held_valid", 64'(out_valid), 64'(1));
    stepCycle();
    out_ready         = 1'b1;
    flag_clear        = 1'b1;
    flag_clear_thread = 2'd2;
    stepCycle();
    flag_clear = 1'b0;
    @(negedge clk);
    checkOutput("clear_then_update", 64'(fp_flags[11:8]), 64'(4'b1000));

    // Backpressure: offer three beats while the consumer stalls for 4 cycles
    stepCycle();
    out_ready = 1'b0;
    outBase   = outCount;
    accepted  = 0;
    applyStimulus();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) accepted++;
      stepCycle();
      if (in_ready && accepted < 3) applyStimulus();
    end
    checkOutput("bp_accepted", 64'(accepted), 64'(2));
    checkOutput("bp_in_ready_low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 10 && accepted < 3; k++) begin
      @(negedge clk);
      if (in_ready) accepted++;
      stepCycle();
    end
    in_valid = 1'b0;
    repeat (5) stepCycle();
    checkOutput("bp_emerged", 64'(outCount - outBase), 64'(3));

    // Randomized traffic with random stalls and clears
    for (int c = 0; c < 400; c++) begin
      stepCycle();
      in_valid          = ($urandom_range(0, 9) < 7);
      out_ready         = ($urandom_range(0, 9) < 7);
      flag_clear        = ($urandom_range(0, 19) == 0);
      flag_clear_thread = TW'($urandom_range(0, NT-1));
      applyStimulus();
    end
    stepCycle();
    in_valid   = 1'b0;
    flag_clear = 1'b0;
    out_ready  = 1'b1;
    repeat (6) stepCycle();
    checkOutput("drain_empty", 64'(sb.size()), 64'(0));

    // Reset in mid-stream with two beats in flight
    out_ready = 1'b0;
    applyStimulus();
    in_valid = 1'b1;
    stepCycle();
    applyStimulus();
    stepCycle();
    in_valid = 1'b0;
    checkOutput("pre_reset_valid", 64'(out_valid), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset_fp_flags", 64'(fp_flags), 64'(0));
    checkOutput("midreset_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("no_stale_beat", 64'(out_valid), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 16, giving the number of independent float32 lanes.
REQ-002 The block SHALL have parameter NUM_THREADS, default 4, giving the number of per-thread sticky flag sets.
REQ-003 The block SHALL use a single clock and an asynchronous, active-low reset; these are the first two ports.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  input beat present.
REQ-007 in_ready  out  1  block accepts a beat; transfer when in_valid && in_ready.
REQ-008 in_thread  in  $clog2(NUM_THREADS)  owning thread.
REQ-009 in_mask  in  NUM_LANES  lane enable.
REQ-010 in_round_mode  in  2  0=RNE, 1=RTZ, 2=RUP, 3=RDN.
REQ-011 in_sign  in  NUM_LANES  per-lane result sign.
REQ-012 in_exponent  in  NUM_LANES x 10  per-lane signed biased exponent before the shift.
REQ-013 in_significand  in  NUM_LANES x 32  per-lane unnormalized significand.
REQ-014 in_norm_shift  in  NUM_LANES x 6  per-lane left normalization shift.
REQ-015 in_inf, in_nan  in  NUM_LANES each  per-lane special-result flags.
REQ-016 out_valid  out  1  result beat present.
REQ-017 out_ready  in  1  consumer accepts the result beat.
REQ-018 out_thread, out_mask  out  as input  carried through with the beat.
REQ-019 out_result  out  NUM_LANES x 32  float32 results.
REQ-020 flag_clear  in  1  clears the flags of flag_clear_thread.
REQ-021 flag_clear_thread  in  $clog2(NUM_THREADS)  thread whose flags are cleared.
REQ-022 fp_flags  out  NUM_THREADS x 4  sticky flags {invalid, overflow, underflow, inexact}.

Function
REQ-023 Pipeline: stage A performs the shift and exponent adjustment; stage B performs rounding and packing; latency is 2 cycles when out_ready is held high.
REQ-024 Throughput: one beat per cycle.
REQ-025 in_ready = !stageA_valid || !stageB_valid || out_ready.
REQ-026 Backpressure: each stage holds its contents while it is full and its downstream stage is not accepting.
REQ-027 Beats are never dropped, duplicated or reordered.
REQ-028 Stage A: s = in_significand << in_norm_shift; e = in_exponent - in_norm_shift (signed, 11 bits).
REQ-029 Bit fields of s: bit 31 = hidden bit, bits 30:8 = mantissa, bit 7 = guard, OR of bits 6:0 = sticky.
REQ-030 Rounding increment: RNE = guard && (sticky || lsb); RTZ = 0; RUP = (guard || sticky) && !sign; RDN = (guard || sticky) && sign.
REQ-031 If the mantissa increment carries out, the mantissa becomes 0 and e is incremented by 1.
REQ-032 Inexact = guard || sticky.
REQ-033 If s == 0, the result is signed zero with no flags.
REQ-034 If e <= 0 with s != 0: the result is signed zero (flush); underflow and inexact are set.
REQ-035 If the final e >= 255: overflow and inexact are set.
REQ-036 Overflow result with RNE, or with the direction matching the sign: signed infinity.
REQ-037 Overflow result otherwise: signed 0x7F7FFFFF (largest finite magnitude).
REQ-038 in_nan: result 0x7FFFFFFF; invalid is set. in_nan has priority over in_inf.
REQ-039 in_inf: result {sign, 8'hFF, 23'd0}; no flags.
REQ-040 Flag update: on each output transfer (out_valid && out_ready), fp_flags[out_thread] |= OR of the flags of lanes with out_mask set.
REQ-041 Masked-off lanes contribute no flags.
REQ-042 Clear and update on the same thread in the same cycle: the clear applies first, then the new flags are ORed in.

Reset
REQ-043 While reset is low: out_valid = 0, both stage valids = 0, fp_flags = 0, in_ready = 1.
REQ-044 Reset asserted during operation discards all in-flight beats.
REQ-045 Datapath registers are not reset.

Configuration
REQ-046 Macro FP_ROUND_MODES_EN defined: all four rounding modes are supported as specified in REQ-030.
REQ-047 Macro FP_ROUND_MODES_EN undefined: in_round_mode is ignored, RNE is always used, and overflow always produces infinity.

Verification
REQ-048 Tie-to-even: s=0x80000180, e=127, shift 0, RNE -> 0x3F800002; inexact set.
REQ-049 Mantissa carry: s=0xFFFFFF80, e=127, RNE -> 0x40000000.
REQ-050 Overflow: s=0xFFFFFF80, e=254, sign 0 -> RNE 0x7F800000 with overflow and inexact; RTZ (macro defined) 0x7F7FFFFF.
REQ-051 Backpressure: 3 beats issued, out_ready low for 4 cycles -> in_ready low after 2 accepted; all 3 emerge in order, none lost.
REQ-052 Flags: lane 5 in_nan with mask bit 5 = 0 -> invalid not set; with mask bit 5 = 1 and flag_clear of the same thread in the same cycle -> invalid = 1.
REQ-053 Reset low mid-stream with 2 beats in flight -> out_valid 0 and fp_flags 0 within the same cycle; no stale beat after reset is released.
